sha_blk_ctrl: RTL and testbench

Block-sequencing controller for the SHA-2 hash core. It accepts message blocks over a valid/ready handshake and latches the hash mode from the first block of each message. It issues the IV-load `start` pulse and the per-block schedule-load pulse, and drives the round counter `cnt` and `hash_size` into the initial-hash/chaining register and the round datapath. When the last block of a message finishes, it presents digest-valid and holds it until the consumer acknowledges.

---
 rtl/sha_blk_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sha_blk_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_blk_ctrl.sv
// Purpose: block sequencer for the SHA-2 core. It latches the mode per message, issues start/blk_load, runs the round counter and holds digest_valid.
// Latency: accept edge T0 -> LOAD at T0+1 -> ROUND with cnt 0..N-1 -> WAIT/OUT at T0+N+2 (N = 64 or 80).
// Backpressure: blk_ready is high only in IDLE and WAIT. digest_valid is held until digest_ack, and blk_ready stays low meanwhile.
module sha_blk_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       blk_valid,
    input  logic       blk_first,
    input  logic       blk_last,
    input  logic [1:0] blk_hash_size,
    output logic       blk_ready,
    output logic       start,
    output logic       blk_load,
    output logic       round_en,
    output logic [6:0] cnt,
    output logic [1:0] hash_size,
    output logic       digest_valid,
    input  logic       digest_ack,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] hs_q, hs_d;
    logic       in_msg_q, in_msg_d;
    logic       last_q, last_d;
    logic       first_q, first_d;
    logic       err_q, err_d;

    logic       accept;
    logic       size_ok;
    logic [6:0] cnt_final;

    // Handshake. The controller takes blocks only between rounds.
    // blk_ready is also held low while reset is asserted.
    assign blk_ready = rst & ((state_q == S_IDLE) | (state_q == S_WAIT));
    assign accept    = blk_valid & blk_ready;
    assign size_ok   = (blk_hash_size != 2'b00);

    // hash_size[1] selects the 64-bit variants, which use 80 rounds.
    assign cnt_final = hs_q[1] ? 7'd79 : 7'd63;

    assign cnt          = cnt_q;
    assign hash_size    = hs_q;
    assign err          = err_q;
    assign start        = (state_q == S_LOAD) & first_q;
    assign blk_load     = (state_q == S_LOAD);
    assign round_en     = (state_q == S_ROUND);
    assign digest_valid = (state_q == S_OUT);
    assign busy         = (state_q != S_IDLE) | in_msg_q;

    // Next-state logic and next values of the latched control fields.
    // cnt defaults to 0 so that it can only be non-zero while in ROUND.
    always_comb begin
        state_d  = state_q;
        cnt_d    = 7'd0;
        hs_d     = hs_q;
        in_msg_d = in_msg_q;
        last_d   = last_q;
        first_d  = first_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (blk_first && size_ok) begin
                        hs_d     = blk_hash_size;
                        in_msg_d = 1'b1;
                        last_d   = blk_last;
                        first_d  = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        // Orphan continuation block or illegal mode: drop the block.
                        err_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (accept) begin
                    if (!blk_first) begin
                        // Continuation block: keep the mode latched at message start.
                        last_d  = blk_last;
                        first_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        // A new first block abandons the current message and is
                        // then handled exactly as a first block arriving in IDLE.
                        err_d = 1'b1;
                        if (size_ok) begin
                            hs_d     = blk_hash_size;
                            in_msg_d = 1'b1;
                            last_d   = blk_last;
                            first_d  = 1'b1;
                            state_d  = S_LOAD;
                        end else begin
                            in_msg_d = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end

            S_LOAD: begin
                cnt_d   = 7'd0;
                state_d = S_ROUND;
            end

            S_ROUND: begin
                if (cnt_q == cnt_final) begin
                    cnt_d = 7'd0;
                    if (last_q) begin
                        in_msg_d = 1'b0;
                        state_d  = S_OUT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            S_OUT: begin
                if (digest_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers. The synchronous reset abandons any message silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 7'd0;
            hs_q     <= 2'b01;
            in_msg_q <= 1'b0;
            last_q   <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hs_q     <= hs_d;
            in_msg_q <= in_msg_d;
            last_q   <= last_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sha_blk_ctrl.sv
// Purpose: directed bench for sha_blk_ctrl that covers single and multi-block messages, protocol errors, reset and the ack hold.
// Latency: inputs change 1ns after a rising edge and outputs are sampled at that point, so a tick moves the bench one cycle forward.
// Backpressure: a block is offered with blk_valid, and the bench waits a bounded time for blk_ready.
module tb_sha_blk_ctrl;

    logic       clk;
    logic       rst;
    logic       blk_valid;
    logic       blk_first;
    logic       blk_last;
    logic [1:0] blk_hash_size;
    logic       blk_ready;
    logic       start;
    logic       blk_load;
    logic       round_en;
    logic [6:0] cnt;
    logic [1:0] hash_size;
    logic       digest_valid;
    logic       digest_ack;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    sha_blk_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .blk_hash_size(blk_hash_size),
        .blk_ready    (blk_ready),
        .start        (start),
        .blk_load     (blk_load),
        .round_en     (round_en),
        .cnt          (cnt),
        .hash_size    (hash_size),
        .digest_valid (digest_valid),
        .digest_ack   (digest_ack),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block and returns in the cycle after the accept edge (the LOAD cycle).
    task automatic accept_block(input logic f, input logic l, input logic [1:0] sz);
        int waited = 0;
        blk_valid = 1'b1; blk_first = f; blk_last = l; blk_hash_size = sz;
        while (!blk_ready && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: blk_ready=%b required 1", blk_ready);
        end
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({blk_ready, start, blk_load, round_en, digest_valid, err, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/st/ld/rnd/dv/err/busy=%b required 0000000",
                     {blk_ready, start, blk_load, round_en, digest_valid, err, busy});
        end
        n_checks++;
        if (cnt !== 7'd0 || hash_size !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_regs: cnt=%0d hash_size=%b required 0 / 01", cnt, hash_size);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: blk_ready=%b required 1", blk_ready);
        end
        tick();
    endtask

    task automatic test_errors();
        // Non-first block while idle.
        accept_block(1'b0, 1'b1, 2'b01);
        n_checks++;
        if (err !== 1'b1 || blk_load !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_nonfirst: err=%b load=%b busy=%b required 1/0/0", err, blk_load, busy);
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || blk_load !== 1'b0 || round_en !== 1'b0) begin
            n_fail++;
            $display("FAIL err_nonfirst_pulse: err=%b load=%b round_en=%b required 0/0/0", err, blk_load, round_en);
        end
        // First block with an illegal mode.
        accept_block(1'b1, 1'b1, 2'b00);
        n_checks++;
        if (err !== 1'b1 || hash_size !== 2'b01 || blk_load !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_size00: err=%b hash_size=%b load=%b busy=%b required 1/01/0/0",
                     err, hash_size, blk_load, busy);
        end
        tick();
        // A first block arriving in WAIT abandons the message and restarts it.
        accept_block(1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 64; i++) tick();
        tick();
        n_checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b1 || digest_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_wait_state: ready=%b busy=%b dv=%b required 1/1/0", blk_ready, busy, digest_valid);
        end
        accept_block(1'b1, 1'b1, 2'b10);
        n_checks++;
        if (err !== 1'b1 || blk_load !== 1'b1 || start !== 1'b1 || hash_size !== 2'b10) begin
            n_fail++;
            $display("FAIL err_first_in_wait: err=%b load=%b start=%b hs=%b required 1/1/1/10",
                     err, blk_load, start, hash_size);
        end
        for (int i = 0; i < 80; i++) tick();
        tick();
        n_checks++;
        if (digest_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_restart_digest: digest_valid=%b required 1 after 80 rounds", digest_valid);
        end
        digest_ack = 1'b1; tick(); digest_ack = 1'b0;
    endtask

    task automatic test_sha256_single();
        int bad = 0;
        accept_block(1'b1, 1'b1, 2'b01);
        n_checks++;
        if (start !== 1'b1 || blk_load !== 1'b1 || cnt !== 7'd0 || round_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL s256_load: start=%b load=%b cnt=%0d round_en=%b busy=%b required 1/1/0/0/1",
                     start, blk_load, cnt, round_en, busy);
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            if (cnt !== 7'(i) || round_en !== 1'b1 || start !== 1'b0 || digest_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL s256_rounds: %0d bad round cycles required 0", bad);
        end
        tick();
        n_checks++;
        if (digest_valid !== 1'b1 || cnt !== 7'd0 || round_en !== 1'b0) begin
            n_fail++;
            $display("FAIL s256_digest: dv=%b cnt=%0d round_en=%b at T0+66 required 1/0/0", digest_valid, cnt, round_en);
        end
        digest_ack = 1'b1; tick(); digest_ack = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL s256_ack: dv=%b ready=%b busy=%b required 0/1/0", digest_valid, blk_ready, busy);
        end
    endtask

    task automatic test_sha512_two();
        int bad = 0;
        accept_block(1'b1, 1'b0, 2'b11);
        n_checks++;
        if (start !== 1'b1 || blk_load !== 1'b1) begin
            n_fail++;
            $display("FAIL s512_load1: start=%b load=%b required 1/1", start, blk_load);
        end
        // Offer the second block early; it must wait for the first WAIT cycle.
        blk_valid = 1'b1; blk_first = 1'b0; blk_last = 1'b1; blk_hash_size = 2'b01;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cnt !== 7'(i) || round_en !== 1'b1 || blk_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL s512_rounds1: %0d bad round cycles required 0", bad);
        end
        tick();
        n_checks++;
        if (blk_ready !== 1'b1 || cnt !== 7'd0 || digest_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL s512_wait: ready=%b cnt=%0d dv=%b busy=%b required 1/0/0/1", blk_ready, cnt, digest_valid, busy);
        end
        tick();
        blk_valid = 1'b0;
        n_checks++;
        if (blk_load !== 1'b1 || start !== 1'b0 || hash_size !== 2'b11) begin
            n_fail++;
            $display("FAIL s512_load2: load=%b start=%b hs=%b required 1/0/11", blk_load, start, hash_size);
        end
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cnt !== 7'(i) || round_en !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL s512_rounds2: %0d bad round cycles required 0", bad);
        end
        tick();
        n_checks++;
        if (digest_valid !== 1'b1 || hash_size !== 2'b11) begin
            n_fail++;
            $display("FAIL s512_digest: dv=%b hs=%b at accept+82 required 1/11", digest_valid, hash_size);
        end
        digest_ack = 1'b1; tick(); digest_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        accept_block(1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 31; i++) tick();
        n_checks++;
        if (cnt !== 7'd30) begin
            n_fail++;
            $display("FAIL rstmid_pre: cnt=%0d required 30", cnt);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (cnt !== 7'd0 || round_en !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_post: cnt=%0d round_en=%b busy=%b ready=%b err=%b required 0/0/0/1/0",
                     cnt, round_en, busy, blk_ready, err);
        end
        tick();
        n_checks++;
        if (round_en !== 1'b0 || digest_valid !== 1'b0 || cnt !== 7'd0) begin
            n_fail++;
            $display("FAIL rstmid_idle: round_en=%b dv=%b cnt=%0d required 0/0/0", round_en, digest_valid, cnt);
        end
    endtask

    task automatic test_ack_hold();
        int bad = 0;
        accept_block(1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 64; i++) tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (digest_valid !== 1'b1 || blk_ready !== 1'b0 || cnt !== 7'd0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL ackhold_hold: %0d bad OUT cycles required 0", bad);
        end
        digest_ack = 1'b1; tick(); digest_ack = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ackhold_release: dv=%b ready=%b busy=%b required 0/1/0", digest_valid, blk_ready, busy);
        end
    endtask

    task automatic test_sha384();
        int bad = 0;
        accept_block(1'b1, 1'b1, 2'b10);
        n_checks++;
        if (hash_size !== 2'b10 || start !== 1'b1) begin
            n_fail++;
            $display("FAIL s384_load: hs=%b start=%b required 10/1", hash_size, start);
        end
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cnt !== 7'(i) || round_en !== 1'b1 || digest_valid !== 1'b0) bad++;
            digest_ack = (i == 10);
        end
        digest_ack = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL s384_rounds: %0d bad round cycles (stray ack) required 0", bad);
        end
        tick();
        n_checks++;
        if (digest_valid !== 1'b1 || hash_size !== 2'b10 || cnt !== 7'd0) begin
            n_fail++;
            $display("FAIL s384_digest: dv=%b hs=%b cnt=%0d required 1/10/0", digest_valid, hash_size, cnt);
        end
        tick();
        n_checks++;
        if (digest_valid !== 1'b1 || hash_size !== 2'b10) begin
            n_fail++;
            $display("FAIL s384_hold: dv=%b hs=%b required 1/10", digest_valid, hash_size);
        end
        digest_ack = 1'b1; tick(); digest_ack = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || hash_size !== 2'b10 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL s384_idle: dv=%b hs=%b ready=%b required 0/10/1", digest_valid, hash_size, blk_ready);
        end
    endtask

    initial begin
        rst = 1'b0;
        blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; blk_hash_size = 2'b01;
        digest_ack = 1'b0;
        #1;
        test_reset();
        test_errors();
        test_sha256_single();
        test_sha512_two();
        test_reset_mid();
        test_ack_hold();
        test_sha384();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
